// File: rtl/fft_frame_sequencer_if.sv
// Purpose: bundles the frame sequencer's control, sample, FFT-core and
//          result-stream signals into one interface.
// Modports:
//   master : the sequencer view (drives s_ready, fft_*, m_*, status)
//   slave  : the environment view (sample source, FFT core, consumer, MCU)
// Signals:
//   arm, continuous          frame control from the MCU
//   s_valid/s_data/s_ready   8-bit sample stream
//   fft_load/fft_rd_adr/fft_rd/fft_start/fft_done/fft_wd  FFT core port
//   m_valid/m_data/m_idx/m_last/m_ready                   result stream
//   busy, overrun, timeout_err, frame_count               status
interface fft_frame_sequencer_if #(
    parameter int unsigned M     = 9,
    parameter int unsigned WIDTH = 16
);
    logic                 arm;
    logic                 continuous;
    logic                 s_valid;
    logic [7:0]           s_data;
    logic                 s_ready;
    logic                 fft_load;
    logic [M-1:0]         fft_rd_adr;
    logic [2*WIDTH-1:0]   fft_rd;
    logic                 fft_start;
    logic                 fft_done;
    logic [2*WIDTH-1:0]   fft_wd;
    logic                 m_valid;
    logic [2*WIDTH-1:0]   m_data;
    logic [M-1:0]         m_idx;
    logic                 m_last;
    logic                 m_ready;
    logic                 busy;
    logic                 overrun;
    logic                 timeout_err;
    logic [15:0]          frame_count;

    modport master (
        input  arm, continuous, s_valid, s_data, fft_done, fft_wd, m_ready,
        output s_ready, fft_load, fft_rd_adr, fft_rd, fft_start,
               m_valid, m_data, m_idx, m_last, busy, overrun, timeout_err,
               frame_count
    );

    modport slave (
        output arm, continuous, s_valid, s_data, fft_done, fft_wd, m_ready,
        input  s_ready, fft_load, fft_rd_adr, fft_rd, fft_start,
               m_valid, m_data, m_idx, m_last, busy, overrun, timeout_err,
               frame_count
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Purpose: frame-level controller for the 2^M-point time-multiplexed FFT core.
//          Loads 2^M unsigned 8-bit samples into the core, pulses start, waits
//          for the core to stream its results and forwards them downstream
//          tagged with bin index and last-word flag.
// Ports:
//   clk    FFT logic clock
//   reset  asynchronous, active-high
//   bus    fft_frame_sequencer_if.master (control, samples, core, results,
//          status); every output is registered and resets to 0
// Configuration:
//   FFT_SEQ_TIMEOUT_EN  when defined, a COMPUTE watchdog aborts the frame
//                       after TIMEOUT cycles without fft_done and sets the
//                       sticky timeout_err; when undefined COMPUTE waits
//                       indefinitely and timeout_err is tied low.
module fft_frame_sequencer #(
    parameter int unsigned M       = 9,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_sequencer_if.master bus
);

    localparam int unsigned WORD_W   = 2 * WIDTH;
    localparam logic [M-1:0] LAST_IDX = M'((1 << M) - 1);

    // Watchdog compare needs at least one cycle of counting.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("fft_frame_sequencer: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_COMPUTE,
        ST_UNLOAD
    } state_e;

    state_e              state_q;
    logic [M-1:0]        load_cnt_q;
    logic [M-1:0]        bin_cnt_q;
    logic                s_ready_q;
    logic                fft_load_q;
    logic [M-1:0]        fft_rd_adr_q;
    logic [WORD_W-1:0]   fft_rd_q;
    logic                fft_start_q;
    logic                m_valid_q;
    logic [WORD_W-1:0]   m_data_q;
    logic [M-1:0]        m_idx_q;
    logic                m_last_q;
    logic                busy_q;
    logic                overrun_q;
    logic [15:0]         frame_count_q;

    logic [M-1:0]        load_cnt_d;
    logic [M-1:0]        bin_cnt_d;
    logic [15:0]         frame_count_d;
    logic                accept;

    assign accept        = s_ready_q & bus.s_valid;
    assign load_cnt_d    = load_cnt_q + M'(1);
    assign bin_cnt_d     = bin_cnt_q + M'(1);
    assign frame_count_d = frame_count_q + 16'd1;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_err_q;
    logic            to_expired;

    assign to_expired      = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Frame state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            load_cnt_q    <= '0;
            bin_cnt_q     <= '0;
            s_ready_q     <= 1'b0;
            fft_load_q    <= 1'b0;
            fft_rd_adr_q  <= '0;
            fft_rd_q      <= '0;
            fft_start_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_idx_q       <= '0;
            m_last_q      <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            fft_load_q  <= 1'b0;
            fft_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;

            // The core cannot be stalled: a word the consumer refuses is lost.
            if (m_valid_q && !bus.m_ready) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_q    <= ST_LOAD;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        overrun_q  <= 1'b0;
                        load_cnt_q <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        fft_load_q   <= 1'b1;
                        fft_rd_adr_q <= load_cnt_q;
                        fft_rd_q     <= {WIDTH'(bus.s_data), WIDTH'(0)};
                        load_cnt_q   <= load_cnt_d;
                        if (load_cnt_q == LAST_IDX) begin
                            state_q   <= ST_START;
                            s_ready_q <= 1'b0;
                        end
                    end
                end

                ST_START: begin
                    fft_start_q <= 1'b1;
                    bin_cnt_q   <= '0;
                    state_q     <= ST_COMPUTE;
`ifdef FFT_SEQ_TIMEOUT_EN
                    to_cnt_q    <= '0;
`endif
                end

                ST_COMPUTE: begin
                    // First done cycle already carries bin 0.
                    if (bus.fft_done) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= bus.fft_wd;
                        m_idx_q   <= bin_cnt_q;
                        m_last_q  <= (bin_cnt_q == LAST_IDX);
                        bin_cnt_q <= bin_cnt_d;
                        state_q   <= ST_UNLOAD;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (to_expired) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end

                ST_UNLOAD: begin
                    // Frame ends the cycle m_last is presented.
                    if (m_last_q) begin
                        frame_count_q <= frame_count_d;
                        load_cnt_q    <= '0;
                        s_ready_q     <= bus.continuous;
                        busy_q        <= bus.continuous;
                        state_q       <= bus.continuous ? ST_LOAD : ST_IDLE;
                    end else if (bus.fft_done) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= bus.fft_wd;
                        m_idx_q   <= bin_cnt_q;
                        m_last_q  <= (bin_cnt_q == LAST_IDX);
                        bin_cnt_q <= bin_cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.fft_load    = fft_load_q;
    assign bus.fft_rd_adr  = fft_rd_adr_q;
    assign bus.fft_rd      = fft_rd_q;
    assign bus.fft_start   = fft_start_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_idx       = m_idx_q;
    assign bus.m_last      = m_last_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Purpose: self-checking bench for fft_frame_sequencer. Loads and results are
//          checked against scoreboard queues filled when stimulus is driven;
//          whole-frame scenarios come from a vector table, corner cases
//          (continuous mode, reset mid-load, stuck core) are hand-written.
module tb_fft_frame_sequencer;

    localparam int unsigned M       = 9;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NPTS    = 512;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.M(M), .WIDTH(WIDTH)) bus ();

    fft_frame_sequencer #(.M(M), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [8:0]  adr;
        logic [31:0] rd;
    } load_exp_t;

    typedef struct {
        logic [8:0]  idx;
        logic [31:0] data;
        logic        last;
    } res_exp_t;

    typedef struct {
        int          s_gap;
        int          d_gap;
        int          lo;
        int          hi;
        logic        ovr;
        logic [15:0] fc;
    } vec_t;

    load_exp_t load_q[$];
    res_exp_t  res_q[$];
    load_exp_t lexp;
    res_exp_t  rexp;
    logic [8:0] exp_adr = '0;
    logic [8:0] exp_bin = '0;
    logic       prev_load = 1'b0;
    int loads_seen   = 0;
    int starts_seen  = 0;
    int results_seen = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return {16'(i * 3 + 1), 16'(16'hFFFF - 16'(i))};
    endfunction

    // Scoreboard monitor: compare outputs, then queue expectations for
    // whatever the bench presents this cycle.
    always @(negedge clk) begin
        if (reset) begin
            load_q.delete();
            res_q.delete();
            exp_adr   = '0;
            exp_bin   = '0;
            prev_load = 1'b0;
        end else begin
            if (bus.fft_load) begin
                loads_seen++;
                if (load_q.size() == 0) begin
                    chk("load_unexpected", 64'd1, 64'd0);
                end else begin
                    lexp = load_q.pop_front();
                    chk("load_adr", 64'(bus.fft_rd_adr), 64'(lexp.adr));
                    chk("load_rd", 64'(bus.fft_rd), 64'(lexp.rd));
                end
            end
            if (bus.fft_start) begin
                starts_seen++;
                chk("start_after_last_load",
                    {62'd0, prev_load, 1'(loads_seen == NPTS * starts_seen)}, 64'd3);
                chk("load_start_overlap", 64'(bus.fft_load), 64'd0);
            end
            prev_load = bus.fft_load;
            if (bus.m_valid) begin
                results_seen++;
                if (res_q.size() == 0) begin
                    chk("result_unexpected", 64'd1, 64'd0);
                end else begin
                    rexp = res_q.pop_front();
                    chk("m_idx", 64'(bus.m_idx), 64'(rexp.idx));
                    chk("m_data", 64'(bus.m_data), 64'(rexp.data));
                    chk("m_last", 64'(bus.m_last), 64'(rexp.last));
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                lexp.adr = exp_adr;
                lexp.rd  = {8'h00, bus.s_data, 16'h0000};
                load_q.push_back(lexp);
                exp_adr++;
            end
            if (bus.fft_done) begin
                rexp.idx  = exp_bin;
                rexp.data = bus.fft_wd;
                rexp.last = (exp_bin == 9'd511);
                res_q.push_back(rexp);
                exp_bin++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        loads_seen   = 0;
        starts_seen  = 0;
        results_seen = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"},
            64'({bus.s_ready, bus.fft_load, bus.fft_start, bus.m_valid, bus.m_last,
                 bus.busy, bus.overrun, bus.timeout_err, bus.frame_count}), 64'd0);
        chk({tag, "_load_bus"}, 64'({bus.fft_rd_adr, bus.fft_rd}), 64'd0);
        chk({tag, "_result_bus"}, 64'({bus.m_idx, bus.m_data}), 64'd0);
    endtask

    task automatic reset_dut();
        bus.arm = 1'b0; bus.s_valid = 1'b0; bus.fft_done = 1'b0; bus.m_ready = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("arm_s_ready", 64'(bus.s_ready), 64'd1);
        chk("arm_busy", 64'(bus.busy), 64'd1);
        chk("arm_clears_overrun", 64'(bus.overrun), 64'd0);
        chk("arm_timeout_err", 64'(bus.timeout_err), 64'd0);
    endtask

    // Present n samples (value = sample number mod 256) with gap idle cycles between accepts.
    task automatic feed(input int n, input int gap);
        int   cnt = 0;
        int   budget = 0;
        logic acc;
        while (cnt < n && budget < 20000) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(cnt);
            acc = bus.s_ready;
            tick();
            budget++;
            if (acc) begin
                cnt++;
                if (cnt < n) begin
                    for (int g = 0; g < gap; g++) begin
                        bus.s_valid = 1'b0;
                        tick();
                        budget++;
                    end
                end
            end
        end
        bus.s_valid = 1'b0;
        if (cnt < n) chk("feed_timeout", 64'(cnt), 64'(n));
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.fft_start) found = 1'b1;
            else tick();
        end
        chk("start_seen", 64'(found), 64'd1);
    endtask

    // Core model: 512 result words, d_gap idle cycles between words,
    // consumer refuses the words of bins lo..hi.
    task automatic stream(input int d_gap, input int lo, input int hi,
                          input logic [15:0] exp_fc, input logic exp_cont);
        int prev = -1;
        repeat (3) tick();
        for (int i = 0; i < NPTS; i++) begin
            bus.m_ready  = !(prev >= lo && prev <= hi);
            bus.fft_done = 1'b1;
            bus.fft_wd   = word(i);
            prev = i;
            tick();
            if (i < NPTS - 1) begin
                for (int g = 0; g < d_gap; g++) begin
                    bus.m_ready  = !(prev >= lo && prev <= hi);
                    bus.fft_done = 1'b0;
                    prev = -1;
                    tick();
                end
            end
        end
        bus.fft_done = 1'b0;
        bus.m_ready  = !(prev >= lo && prev <= hi);
        chk("m_last_on_511", 64'({bus.m_valid, bus.m_last, bus.m_idx}), 64'({1'b1, 1'b1, 9'd511}));
        chk("fc_before_update", 64'(bus.frame_count), 64'(16'(exp_fc - 16'd1)));
        tick();
        bus.m_ready = 1'b1;
        chk("frame_count", 64'(bus.frame_count), 64'(exp_fc));
        chk("s_ready_after_last", 64'(bus.s_ready), 64'(exp_cont));
        chk("busy_after_last", 64'(bus.busy), 64'(exp_cont));
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{0, 0, 1000, 0,   1'b0, 16'd1};  // back-to-back samples and results
        vecs[1] = '{1, 0, 1000, 0,   1'b0, 16'd2};  // s_valid toggling
        vecs[2] = '{0, 0, 100,  102, 1'b1, 16'd3};  // consumer drops bins 100..102
        vecs[3] = '{2, 1, 1000, 0,   1'b0, 16'd4};  // sparse samples and done gaps

        bus.arm = 1'b0; bus.continuous = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        bus.fft_done = 1'b0; bus.fft_wd = '0; bus.m_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Samples offered while idle must not be taken.
        bus.s_valid = 1'b1;
        repeat (3) tick();
        chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        bus.s_valid = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            clear_stats();
            arm_pulse();
            feed(NPTS, vecs[v].s_gap);
            wait_start();
            stream(vecs[v].d_gap, vecs[v].lo, vecs[v].hi, vecs[v].fc, 1'b0);
            chk("loads_per_frame", 64'(loads_seen), 64'(NPTS));
            chk("starts_per_frame", 64'(starts_seen), 64'd1);
            chk("results_per_frame", 64'(results_seen), 64'(NPTS));
            chk("overrun", 64'(bus.overrun), 64'(vecs[v].ovr));
            repeat (3) tick();
            chk("overrun_held", 64'(bus.overrun), 64'(vecs[v].ovr));
            chk("idle_after_frame", 64'({bus.s_ready, bus.busy, bus.timeout_err}), 64'd0);
        end

        // Continuous mode: three frames with no idle cycles, then reset mid-load.
        reset_dut();
        bus.continuous = 1'b1;
        clear_stats();
        arm_pulse();
        for (int f = 0; f < 3; f++) begin
            feed(NPTS, 0);
            wait_start();
            stream(0, 1000, 0, 16'(f + 1), 1'b1);
        end
        chk("cont_starts", 64'(starts_seen), 64'd3);
        chk("cont_results", 64'(results_seen), 64'(3 * NPTS));
        feed(200, 0);
        reset = 1'b1;
        #1;
        check_all_zero("mid_load_reset");
        tick();
        reset = 1'b0;
        bus.continuous = 1'b0;
        tick();
        check_all_zero("after_reset");
        clear_stats();
        arm_pulse();
        feed(NPTS, 0);
        wait_start();
        stream(0, 1000, 0, 16'd1, 1'b0);
        chk("post_reset_loads", 64'(loads_seen), 64'(NPTS));

        // Core never signals done.
        clear_stats();
        arm_pulse();
        feed(NPTS, 0);
        wait_start();
        repeat (TIMEOUT - 1) tick();
        chk("compute_pre_timeout", 64'({bus.busy, bus.timeout_err}), 64'({1'b1, 1'b0}));
        tick();
`ifdef FFT_SEQ_TIMEOUT_EN
        chk("timeout_abort", 64'({bus.busy, bus.timeout_err, bus.s_ready}), 64'({1'b1 ^ 1'b1, 1'b1, 1'b0}));
        repeat (5) tick();
        chk("timeout_sticky", 64'(bus.timeout_err), 64'd1);
`else
        chk("compute_waits", 64'({bus.busy, bus.timeout_err, bus.s_ready}), 64'({1'b1, 1'b0, 1'b0}));
        repeat (40) tick();
        chk("compute_still_waits", 64'({bus.busy, bus.timeout_err, bus.m_valid}), 64'({1'b1, 1'b0, 1'b0}));
`endif
        reset_dut();
        chk("load_queue_drained", 64'(load_q.size()), 64'd0);
        chk("result_queue_drained", 64'(res_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
